gpio_input_debouncer: RTL and testbench

Conditions the eight raw board switches before they reach the GPIO port's input register. Each bit passes through a synchronizer, then a per-bit stability counter; a debounced level is presented on `Switch_Out`, which connects directly to the `GPIO_Port_In` bus of the GPIO port. The block also produces per-bit rise and fall pulses and a sticky change flag for future polling or interrupt use. It sits between the board pins and the memory-mapped GPIO port.

---
 rtl/gpio_defs.sv | 6 +
 rtl/debounce_bit.sv | 46 ++++
 rtl/gpio_input_debouncer.sv | 41 ++++
 tb/tb_gpio_input_debouncer.sv | 97 +++++++++
 4 files changed

// File: rtl/gpio_defs.sv
// gpio_defs: shared GPIO widths and debounce timing defaults.
package gpio_defs;
  localparam int GPIO_WIDTH = 8;
  localparam int DEBOUNCE_STABLE_CYCLES = 500000;
  localparam int DEBOUNCE_SYNC_STAGES = 2;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: synchronizer, stability counter, debounced level and edge pulses for one switch.
module debounce_bit #(
  parameter int SYNC_STAGES = gpio_defs::DEBOUNCE_SYNC_STAGES,
  parameter int STABLE_CYCLES = gpio_defs::DEBOUNCE_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o,
  output logic chg_o
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic out_q, rise_q, fall_q;
  logic synced, diff, accept;
  always_comb begin
    synced = sync_q[SYNC_STAGES-1];
    diff = synced ^ out_q;
    accept = diff && (cnt_q == LAST);
    // Any agreement with the accepted level, or an acceptance, restarts the count.
    cnt_d = (!diff || accept) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      out_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      cnt_q <= cnt_d;
      out_q <= accept ? synced : out_q;
      rise_q <= accept && synced;
      fall_q <= accept && !synced;
    end
  end
  assign dout_o = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign chg_o = accept;
endmodule

// File: rtl/gpio_input_debouncer.sv
// gpio_input_debouncer: per-bit debouncers for the board switches plus a sticky change flag.
module gpio_input_debouncer
  import gpio_defs::*;
#(
  parameter int WIDTH = GPIO_WIDTH,
  parameter int SYNC_STAGES = DEBOUNCE_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Switch_In,
  output logic [WIDTH-1:0] Switch_Out,
  output logic [WIDTH-1:0] Rise_Pulse,
  output logic [WIDTH-1:0] Fall_Pulse,
  output logic             Change_Flag,
  input  logic             Flag_Clear
);
  logic [WIDTH-1:0] chg;
  logic change_flag_q, change_flag_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk(clk),
      .rst(rst),
      .din_i(Switch_In[i]),
      .dout_o(Switch_Out[i]),
      .rise_o(Rise_Pulse[i]),
      .fall_o(Fall_Pulse[i]),
      .chg_o(chg[i])
    );
  end
  // A pulse registering on this edge beats a simultaneous clear.
  always_comb change_flag_d = |chg ? 1'b1 : Flag_Clear ? 1'b0 : change_flag_q;
  always_ff @(posedge clk) begin
    if (rst) change_flag_q <= 1'b0;
    else change_flag_q <= change_flag_d;
  end
  assign Change_Flag = change_flag_q;
endmodule

// File: tb/tb_gpio_input_debouncer.sv
// tb_gpio_input_debouncer: cycle-by-cycle vector table plus a reset-mid-count sequence.
module tb_gpio_input_debouncer;
  typedef struct {
    logic       rst;
    logic       clr;
    logic [7:0] sw;
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       flag;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [7:0] sw_out, rise_p, fall_p;
  logic flag;
  int n_chk = 0;
  int n_fail = 0;
  vec_t v[$];
  always #5 clk = ~clk;
  gpio_input_debouncer #(.WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .Switch_In(sw),
    .Switch_Out(sw_out),
    .Rise_Pulse(rise_p),
    .Fall_Pulse(fall_p),
    .Change_Flag(flag),
    .Flag_Clear(clr)
  );
  task automatic add(input int n, input logic r, input logic c, input logic [7:0] s,
                     input logic [7:0] o, input logic [7:0] ri, input logic [7:0] fa, input logic fl);
    vec_t e;
    e.rst = r; e.clr = c; e.sw = s; e.out = o; e.rise = ri; e.fall = fa; e.flag = fl;
    for (int k = 0; k < n; k++) v.push_back(e);
  endtask
  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic step(input int idx, input vec_t e);
    rst = e.rst; clr = e.clr; sw = e.sw;
    @(posedge clk);
    #1;
    chk("switch_out", idx, sw_out, e.out);
    chk("rise_pulse", idx, rise_p, e.rise);
    chk("fall_pulse", idx, fall_p, e.fall);
    chk("change_flag", idx, {7'd0, flag}, {7'd0, e.flag});
  endtask
  initial begin
    vec_t e;
    add(3, 1, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
    add(1, 0, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1);
    add(1, 0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
    add(5, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 1);
    add(1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 0, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h01, 8'h01, 8'h01, 8'h00, 1);
    add(1, 0, 0, 8'h01, 8'h01, 8'h00, 8'h00, 1);
    add(5, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 1);
    add(1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h01, 1);
    add(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    add(1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h08, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h08, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 0, 8'h08, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h08, 8'h08, 8'h08, 8'h00, 1);
    add(1, 0, 0, 8'h08, 8'h08, 8'h00, 8'h00, 1);
    add(1, 0, 1, 8'h08, 8'h08, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h0C, 8'h08, 8'h00, 8'h00, 0);
    add(4, 0, 0, 8'h8C, 8'h08, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h8C, 8'h0C, 8'h04, 8'h00, 1);
    add(1, 0, 0, 8'h8C, 8'h8C, 8'h80, 8'h00, 1);
    add(1, 0, 0, 8'h8C, 8'h8C, 8'h00, 8'h00, 1);
    for (int i = 0; i < v.size(); i++) step(i, v[i]);
    e.clr = 0; e.fall = 8'h00; e.rise = 8'h00; e.out = 8'h00; e.flag = 0;
    e.rst = 1; e.sw = 8'h00; step(100, e);
    e.rst = 0; e.sw = 8'h20;
    for (int k = 0; k < 3; k++) step(101 + k, e);
    e.rst = 1; step(104, e);
    e.rst = 0;
    for (int k = 0; k < 5; k++) step(105 + k, e);
    e.out = 8'h20; e.rise = 8'h20; e.flag = 1; step(110, e);
    e.rise = 8'h00; step(111, e);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
